// File: rtl/tok_dispatch_ctrl.sv
// Decimal token parser and rotating-priority dispatcher to NUM_LANES lanes.
// Optional TOK_DISPATCH_LANE_MASK_EN adds i_lane_mask lane eligibility.
module tok_dispatch_ctrl #(
  parameter int NUM_LANES = 4,
  parameter int DATA_W    = 32,
  parameter int CNT_W     = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [7:0]           i_char,
  input  logic                 i_vld,
  output logic                 o_stall,
  input  logic                 i_eof,
  output logic [NUM_LANES-1:0] o_lane_vld,
  output logic [DATA_W-1:0]    o_lane_data,
  output logic                 o_lane_eol,
  input  logic [NUM_LANES-1:0] i_lane_rdy,
`ifdef TOK_DISPATCH_LANE_MASK_EN
  input  logic [NUM_LANES-1:0] i_lane_mask,
`endif
  output logic [CNT_W-1:0]     o_tok_cnt,
  output logic                 o_ovf,
  output logic                 o_done
);

  localparam int PW = $clog2(NUM_LANES);
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_NUM  = 2'd1;
  localparam logic [1:0] S_PEND = 2'd2;

  logic [1:0]           state, n_state;
  logic [DATA_W-1:0]    acc, n_acc;
  logic [DATA_W-1:0]    pend_data, n_pdata;
  logic                 pend_eol, n_peol;
  logic                 eof_pend, n_eofp;
  logic                 done, n_done;
  logic                 ovf_hit, xfer;
  logic [PW-1:0]        rr_ptr;
  logic [CNT_W-1:0]     tok_cnt;
  logic                 ovf;

  logic [NUM_LANES-1:0]   elig;
  logic [2*NUM_LANES-1:0] dbl;
  logic [PW-1:0]          k, gidx;
  logic [PW:0]            sum, nxt;
  logic                   found;
  logic [NUM_LANES-1:0]   gnt;

  logic                 take, is_dig;
  logic [3:0]           dig4;
  logic [DATA_W+3:0]    wide;

  // Lane eligibility, optionally qualified by the mask
`ifdef TOK_DISPATCH_LANE_MASK_EN
  assign elig = i_lane_rdy & i_lane_mask;
`else
  assign elig = i_lane_rdy;
`endif

  // Rotating-priority search starting at rr_ptr
  always_comb begin
    dbl   = {elig, elig} >> rr_ptr;
    found = |elig;
    k     = '0;
    for (int i = NUM_LANES - 1; i >= 0; i--) begin
      if (dbl[i]) k = PW'(i);
    end
    sum = {1'b0, rr_ptr} + {1'b0, k};
    if (sum >= (PW+1)'(NUM_LANES)) sum = sum - (PW+1)'(NUM_LANES);
    gidx = sum[PW-1:0];
    gnt  = {{(NUM_LANES-1){1'b0}}, 1'b1} << gidx;
    nxt  = {1'b0, gidx} + (PW+1)'(1);
    if (nxt == (PW+1)'(NUM_LANES)) nxt = '0;
  end

  assign take   = i_vld & ~o_stall;
  assign is_dig = (i_char >= 8'h30) && (i_char <= 8'h39);
  assign dig4   = i_char[3:0];
  assign wide   = {4'b0, acc} * (DATA_W+4)'(10) + (DATA_W+4)'(dig4);

  // Next-state: character first, then eof closes any open token
  always_comb begin
    n_state = state;
    n_acc   = acc;
    n_pdata = pend_data;
    n_peol  = pend_eol;
    n_eofp  = eof_pend;
    n_done  = 1'b0;
    ovf_hit = 1'b0;
    xfer    = 1'b0;
    case (state)
      S_IDLE, S_NUM: begin
        if (take) begin
          if (is_dig) begin
            n_state = S_NUM;
            if (state == S_IDLE) begin
              n_acc = DATA_W'(dig4);
            end else begin
              n_acc   = wide[DATA_W-1:0];
              ovf_hit = |wide[DATA_W+3:DATA_W];
            end
          end else if (state == S_NUM) begin
            n_state = S_PEND;
            n_pdata = acc;
            n_peol  = (i_char == 8'h0A);
          end
        end
        if (i_eof) begin
          if (n_state == S_NUM) begin
            n_state = S_PEND;
            n_pdata = n_acc;
            n_peol  = 1'b1;
            n_eofp  = 1'b1;
          end else if (n_state == S_PEND) begin
            n_peol = 1'b1;
            n_eofp = 1'b1;
          end else begin
            n_done = 1'b1;
          end
        end
      end
      S_PEND: begin
        if (found) begin
          xfer    = 1'b1;
          n_state = S_IDLE;
          n_eofp  = 1'b0;
          n_done  = eof_pend;
        end
      end
      default: n_state = S_IDLE;
    endcase
  end

  // State and datapath registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      acc       <= '0;
      pend_data <= '0;
      pend_eol  <= 1'b0;
      eof_pend  <= 1'b0;
      done      <= 1'b0;
      rr_ptr    <= '0;
      tok_cnt   <= '0;
      ovf       <= 1'b0;
    end else begin
      state     <= n_state;
      acc       <= n_acc;
      pend_data <= n_pdata;
      pend_eol  <= n_peol;
      eof_pend  <= n_eofp;
      done      <= n_done;
      ovf       <= ovf | ovf_hit;
      if (xfer) begin
        rr_ptr  <= nxt[PW-1:0];
        tok_cnt <= tok_cnt + CNT_W'(1);
      end
    end
  end

  assign o_stall     = (state == S_PEND);
  assign o_lane_vld  = (o_stall && found) ? gnt : '0;
  assign o_lane_data = pend_data;
  assign o_lane_eol  = pend_eol;
  assign o_tok_cnt   = tok_cnt;
  assign o_ovf       = ovf;
  assign o_done      = done;

endmodule

// File: tb/tb_tok_dispatch_ctrl.sv
// Directed self-checking bench for tok_dispatch_ctrl.
// Covers TOK_DISPATCH_LANE_MASK_EN when the macro is defined.
module tb_tok_dispatch_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  i_char;
  logic        i_vld;
  logic        o_stall;
  logic        i_eof;
  logic [3:0]  o_lane_vld;
  logic [31:0] o_lane_data;
  logic        o_lane_eol;
  logic [3:0]  i_lane_rdy;
`ifdef TOK_DISPATCH_LANE_MASK_EN
  logic [3:0]  i_lane_mask;
`endif
  logic [15:0] o_tok_cnt;
  logic        o_ovf;
  logic        o_done;

  int errors = 0;
  int checks = 0;

  tok_dispatch_ctrl #(.NUM_LANES(4), .DATA_W(32), .CNT_W(16)) dut (
    .clk(clk),
    .rst(rst),
    .i_char(i_char),
    .i_vld(i_vld),
    .o_stall(o_stall),
    .i_eof(i_eof),
    .o_lane_vld(o_lane_vld),
    .o_lane_data(o_lane_data),
    .o_lane_eol(o_lane_eol),
    .i_lane_rdy(i_lane_rdy),
`ifdef TOK_DISPATCH_LANE_MASK_EN
    .i_lane_mask(i_lane_mask),
`endif
    .o_tok_cnt(o_tok_cnt),
    .o_ovf(o_ovf),
    .o_done(o_done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chr(input logic [7:0] c);
    i_char = c;
    i_vld  = 1'b1;
    tick();
    i_vld  = 1'b0;
  endtask

  task automatic feed(input string s);
    for (int i = 0; i < s.len(); i++) chr(s[i]);
  endtask

  task automatic offer(input string tag, input logic [3:0] v,
                       input logic [31:0] d, input logic e);
    chk({tag, "_stall"}, o_stall, 1'b1);
    chk({tag, "_vld"}, o_lane_vld, v);
    chk({tag, "_data"}, o_lane_data, d);
    chk({tag, "_eol"}, o_lane_eol, e);
    tick();
    chk({tag, "_unstall"}, o_stall, 1'b0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  initial begin
    i_char = 8'h00;
    i_vld = 1'b0;
    i_eof = 1'b0;
    i_lane_rdy = 4'hF;
`ifdef TOK_DISPATCH_LANE_MASK_EN
    i_lane_mask = 4'hF;
`endif
    do_reset();

    chk("rst_stall", o_stall, 1'b0);
    chk("rst_vld", o_lane_vld, 4'h0);
    chk("rst_data", o_lane_data, 32'd0);
    chk("rst_cnt", o_tok_cnt, 16'd0);
    chk("rst_ovf", o_ovf, 1'b0);
    chk("rst_done", o_done, 1'b0);

    feed("12");
    chk("t1_nostall", o_stall, 1'b0);
    chr(" ");
    offer("t1_a", 4'b0001, 32'd12, 1'b0);
    feed("345");
    chr(8'h0A);
    offer("t1_b", 4'b0010, 32'd345, 1'b1);
    chk("t1_cnt", o_tok_cnt, 16'd2);

    do_reset();
    feed("7");  chr(","); offer("t2_7", 4'b0001, 32'd7, 1'b0);
    feed("8");  chr(","); offer("t2_8", 4'b0010, 32'd8, 1'b0);
    feed("9");  chr(","); offer("t2_9", 4'b0100, 32'd9, 1'b0);
    feed("10"); chr(","); offer("t2_10", 4'b1000, 32'd10, 1'b0);
    feed("11");
    i_eof = 1'b1;
    tick();
    i_eof = 1'b0;
    chk("t2_done_pre", o_done, 1'b0);
    offer("t2_11", 4'b0001, 32'd11, 1'b1);
    chk("t2_done", o_done, 1'b1);
    tick();
    chk("t2_done_end", o_done, 1'b0);
    chk("t2_cnt", o_tok_cnt, 16'd5);

    i_lane_rdy = 4'h0;
    feed("5");
    chr(" ");
    for (int i = 0; i < 20; i++) begin
      chk("t3_hold_stall", o_stall, 1'b1);
      chk("t3_hold_vld", o_lane_vld, 4'h0);
      tick();
    end
    i_lane_rdy = 4'b0100;
    #1;
    offer("t3_5", 4'b0100, 32'd5, 1'b0);
    i_lane_rdy = 4'hF;
    feed("6");
    chr(" ");
    offer("t3_rr", 4'b1000, 32'd6, 1'b0);

    feed("429496729");
    chk("t4_ovf_pre", o_ovf, 1'b0);
    feed("6");
    chk("t4_ovf_set", o_ovf, 1'b1);
    chr(" ");
    offer("t4_zero", 4'b0001, 32'd0, 1'b0);
    feed("3");
    chr(" ");
    offer("t4_3", 4'b0010, 32'd3, 1'b0);
    chk("t4_ovf_sticky", o_ovf, 1'b1);

    i_lane_rdy = 4'h0;
    feed("99");
    chr(" ");
    chk("t5_pend", o_lane_data, 32'd99);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    i_lane_rdy = 4'hF;
    #1;
    chk("t5_stall", o_stall, 1'b0);
    chk("t5_vld", o_lane_vld, 4'h0);
    chk("t5_data", o_lane_data, 32'd0);
    chk("t5_eol", o_lane_eol, 1'b0);
    chk("t5_cnt", o_tok_cnt, 16'd0);
    chk("t5_ovf", o_ovf, 1'b0);
    chk("t5_done", o_done, 1'b0);
    feed("1");
    chr(" ");
    offer("t5_1", 4'b0001, 32'd1, 1'b0);

    i_eof = 1'b1;
    tick();
    i_eof = 1'b0;
    chk("t6_idle_done", o_done, 1'b1);
    tick();
    chk("t6_idle_done_end", o_done, 1'b0);
    feed("4");
    i_char = "2";
    i_vld = 1'b1;
    i_eof = 1'b1;
    tick();
    i_vld = 1'b0;
    i_eof = 1'b0;
    offer("t6_42", 4'b0010, 32'd42, 1'b1);
    chk("t6_done", o_done, 1'b1);

`ifdef TOK_DISPATCH_LANE_MASK_EN
    do_reset();
    i_lane_mask = 4'b1010;
    feed("1"); chr(" "); offer("t7_1", 4'b0010, 32'd1, 1'b0);
    feed("2"); chr(" "); offer("t7_2", 4'b1000, 32'd2, 1'b0);
    feed("3"); chr(" "); offer("t7_3", 4'b0010, 32'd3, 1'b0);
    i_lane_mask = 4'h0;
    feed("8");
    chr(" ");
    for (int i = 0; i < 5; i++) begin
      chk("t7_mask0_vld", o_lane_vld, 4'h0);
      tick();
    end
    chk("t7_mask0_stall", o_stall, 1'b1);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
